axi_lite_conf_master: RTL and testbench

//  AXI4-Lite initiator that walks a configuration list at start-up and programs register-mapped IP cores (ClockDetector etc.).

---
 rtl/tc_conf_pkg.sv | 33 +++
 rtl/conf_phase_timer.sv | 35 +++
 rtl/axi_lite_conf_master.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_conf_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_conf_pkg.sv
// Shared definitions for the AXI4-Lite configuration master: list entry layout, opcodes,
// FSM states and AXI response codes.
package tc_conf_pkg;

    typedef enum logic [1:0] {
        CONF_OP_WRITE = 2'd0,
        CONF_OP_READ  = 2'd1,
        CONF_OP_WAIT  = 2'd2,
        CONF_OP_END   = 2'd3
    } conf_op_e;

    // ROM entry layout: {Op[1:0], Addr[31:0], Data[31:0]}
    localparam int unsigned EntryWidth   = 66;
    localparam int unsigned EntryDataLsb = 0;
    localparam int unsigned EntryAddrLsb = 32;
    localparam int unsigned EntryOpLsb   = 64;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StWait,
        StError,
        StDone
    } conf_state_e;

endpackage

// File: rtl/conf_phase_timer.sv
// Loadable down-counter; expired_o is high while the count is zero. Serves both as the
// per-phase AXI timeout and as the WAIT-entry delay.
module conf_phase_timer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/axi_lite_conf_master.sv
// AXI4-Lite initiator that walks a ROM-held configuration list at start-up.
// Define CONF_MASTER_VERIFY_EN to read back and compare every successful WRITE.
module axi_lite_conf_master
    import tc_conf_pkg::*;
#(
    parameter int unsigned ListSize_Gen      = 256,
    parameter int unsigned TimeoutCycles_Gen = 1024,
    localparam int unsigned IdxW             = $clog2(ListSize_Gen)
) (
    input  logic                  SysClk_ClkIn,
    input  logic                  SysRst_RstIn,
    input  logic                  ConfStart_EvtIn,
    output logic [IdxW-1:0]       ConfigIndex_AdrOut,
    input  logic [EntryWidth-1:0] ConfigEntry_DatIn,
    output logic                  ConfDone_ValOut,
    output logic                  ConfError_ValOut,
    output logic [IdxW-1:0]       ConfErrorIndex_DatOut,
    output logic [31:0]           LastReadData_DatOut,
    output logic                  AxiWriteAddrValid_ValOut,
    input  logic                  AxiWriteAddrReady_RdyIn,
    output logic [31:0]           AxiWriteAddrAddress_AdrOut,
    output logic [2:0]            AxiWriteAddrProt_DatOut,
    output logic                  AxiWriteDataValid_ValOut,
    input  logic                  AxiWriteDataReady_RdyIn,
    output logic [31:0]           AxiWriteDataData_DatOut,
    output logic [3:0]            AxiWriteDataStrobe_DatOut,
    input  logic                  AxiWriteRespValid_ValIn,
    output logic                  AxiWriteRespReady_RdyOut,
    input  logic [1:0]            AxiWriteRespResponse_DatIn,
    output logic                  AxiReadAddrValid_ValOut,
    input  logic                  AxiReadAddrReady_RdyIn,
    output logic [31:0]           AxiReadAddrAddress_AdrOut,
    output logic [2:0]            AxiReadAddrProt_DatOut,
    input  logic                  AxiReadDataValid_ValIn,
    output logic                  AxiReadDataReady_RdyOut,
    input  logic [1:0]            AxiReadDataResponse_DatIn,
    input  logic [31:0]           AxiReadDataData_DatIn
);

    localparam logic [31:0] TimeoutLoad = 32'(TimeoutCycles_Gen - 1);

    conf_state_e     state_d, state_q;
    logic [IdxW-1:0] index_d, index_q;
    logic [31:0]     addr_d, addr_q;
    logic [31:0]     data_d, data_q;
    logic            awvalid_d, awvalid_q;
    logic            wvalid_d, wvalid_q;
    logic            aw_done_d, aw_done_q;
    logic            w_done_d, w_done_q;
    logic            bready_d, bready_q;
    logic            arvalid_d, arvalid_q;
    logic            rready_d, rready_q;
    logic            done_d, done_q;
    logic            error_d, error_q;
    logic [IdxW-1:0] err_idx_d, err_idx_q;
    logic [31:0]     last_rd_d, last_rd_q;
`ifdef CONF_MASTER_VERIFY_EN
    conf_op_e        op_d, op_q;
`endif

    conf_op_e        entry_op;
    logic [31:0]     entry_addr;
    logic [31:0]     entry_data;
    logic            last_entry;
    logic            advance;
    logic            abort;
    logic            timer_load;
    logic [31:0]     timer_load_val;
    logic            timer_en;
    logic            timer_expired;

    assign entry_op   = conf_op_e'(ConfigEntry_DatIn[EntryOpLsb +: 2]);
    assign entry_addr = ConfigEntry_DatIn[EntryAddrLsb +: 32];
    assign entry_data = ConfigEntry_DatIn[EntryDataLsb +: 32];
    assign last_entry = (index_q == IdxW'(ListSize_Gen - 1));

    conf_phase_timer #(
        .Width (32)
    ) u_timer (
        .clk_i      (SysClk_ClkIn),
        .rst_i      (SysRst_RstIn),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .en_i       (timer_en),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        addr_d         = addr_q;
        data_d         = data_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        done_d         = done_q;
        error_d        = error_q;
        err_idx_d      = err_idx_q;
        last_rd_d      = last_rd_q;
`ifdef CONF_MASTER_VERIFY_EN
        op_d           = op_q;
`endif
        timer_load     = 1'b0;
        timer_load_val = TimeoutLoad;
        timer_en       = 1'b0;
        advance        = 1'b0;
        abort          = 1'b0;

        case (state_q)
            StIdle: begin
                index_d = '0;
                state_d = StFetch;
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                addr_d = entry_addr;
                data_d = entry_data;
`ifdef CONF_MASTER_VERIFY_EN
                op_d   = entry_op;
`endif
                case (entry_op)
                    CONF_OP_WRITE: begin
                        awvalid_d  = 1'b1;
                        wvalid_d   = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                        timer_load = 1'b1;
                        state_d    = StWrReq;
                    end
                    CONF_OP_READ: begin
                        arvalid_d  = 1'b1;
                        timer_load = 1'b1;
                        state_d    = StRdReq;
                    end
                    CONF_OP_WAIT: begin
                        timer_load     = 1'b1;
                        timer_load_val = entry_data;
                        state_d        = StWait;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                endcase
            end
            StWrReq: begin
                timer_en = 1'b1;
                // Completion is judged on registered flags, so VALIDs are already low here.
                if (aw_done_q && w_done_q) begin
                    bready_d   = 1'b1;
                    timer_load = 1'b1;
                    state_d    = StWrResp;
                end else begin
                    if (awvalid_q && AxiWriteAddrReady_RdyIn) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                    if (wvalid_q && AxiWriteDataReady_RdyIn) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                    if (timer_expired) begin
                        abort = 1'b1;
                    end
                end
            end
            StWrResp: begin
                timer_en = 1'b1;
                if (AxiWriteRespValid_ValIn) begin
                    bready_d = 1'b0;
                    if (AxiWriteRespResponse_DatIn != AXI_RESP_OKAY) begin
                        state_d = StError;
                    end else begin
`ifdef CONF_MASTER_VERIFY_EN
                        arvalid_d  = 1'b1;
                        timer_load = 1'b1;
                        state_d    = StRdReq;
`else
                        advance = 1'b1;
`endif
                    end
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            StRdReq: begin
                timer_en = 1'b1;
                if (AxiReadAddrReady_RdyIn) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    timer_load = 1'b1;
                    state_d    = StRdResp;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            StRdResp: begin
                timer_en = 1'b1;
                if (AxiReadDataValid_ValIn) begin
                    rready_d  = 1'b0;
                    last_rd_d = AxiReadDataData_DatIn;
                    if (AxiReadDataResponse_DatIn != AXI_RESP_OKAY) begin
                        state_d = StError;
`ifdef CONF_MASTER_VERIFY_EN
                    end else if ((op_q == CONF_OP_WRITE) && (AxiReadDataData_DatIn != data_q)) begin
                        state_d = StError;
`endif
                    end else begin
                        advance = 1'b1;
                    end
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            StWait: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    advance = 1'b1;
                end
            end
            StError: begin
                error_d   = 1'b1;
                err_idx_d = index_q;
                done_d    = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                if (ConfStart_EvtIn) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            state_d   = StError;
        end

        // Running off the end of the list behaves like an END entry.
        if (advance) begin
            if (last_entry) begin
                done_d  = 1'b1;
                state_d = StDone;
            end else begin
                index_d = index_q + IdxW'(1);
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge SysClk_ClkIn) begin
        if (SysRst_RstIn) begin
            state_q   <= StIdle;
            index_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            last_rd_q <= '0;
`ifdef CONF_MASTER_VERIFY_EN
            op_q      <= CONF_OP_END;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            last_rd_q <= last_rd_d;
`ifdef CONF_MASTER_VERIFY_EN
            op_q      <= op_d;
`endif
        end
    end

    assign ConfigIndex_AdrOut         = index_q;
    assign ConfDone_ValOut            = done_q;
    assign ConfError_ValOut           = error_q;
    assign ConfErrorIndex_DatOut      = err_idx_q;
    assign LastReadData_DatOut        = last_rd_q;
    assign AxiWriteAddrValid_ValOut   = awvalid_q;
    assign AxiWriteAddrAddress_AdrOut = addr_q;
    assign AxiWriteAddrProt_DatOut    = 3'b000;
    assign AxiWriteDataValid_ValOut   = wvalid_q;
    assign AxiWriteDataData_DatOut    = data_q;
    assign AxiWriteDataStrobe_DatOut  = 4'hF;
    assign AxiWriteRespReady_RdyOut   = bready_q;
    assign AxiReadAddrValid_ValOut    = arvalid_q;
    assign AxiReadAddrAddress_AdrOut  = addr_q;
    assign AxiReadAddrProt_DatOut     = 3'b000;
    assign AxiReadDataReady_RdyOut    = rready_q;

endmodule

// File: tb/tb_axi_lite_conf_master.sv
// Directed bench for axi_lite_conf_master: ROM model, simple AXI4-Lite slave, bus monitor.
module tb_axi_lite_conf_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_idx;
    logic [65:0] cfg_entry;
    logic        conf_done, conf_err;
    logic [7:0]  err_idx;
    logic [31:0] last_rd;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_conf_master u_dut (
        .SysClk_ClkIn               (clk),
        .SysRst_RstIn               (rst),
        .ConfStart_EvtIn            (start),
        .ConfigIndex_AdrOut         (cfg_idx),
        .ConfigEntry_DatIn          (cfg_entry),
        .ConfDone_ValOut            (conf_done),
        .ConfError_ValOut           (conf_err),
        .ConfErrorIndex_DatOut      (err_idx),
        .LastReadData_DatOut        (last_rd),
        .AxiWriteAddrValid_ValOut   (awvalid),
        .AxiWriteAddrReady_RdyIn    (awready),
        .AxiWriteAddrAddress_AdrOut (awaddr),
        .AxiWriteAddrProt_DatOut    (awprot),
        .AxiWriteDataValid_ValOut   (wvalid),
        .AxiWriteDataReady_RdyIn    (wready),
        .AxiWriteDataData_DatOut    (wdata),
        .AxiWriteDataStrobe_DatOut  (wstrb),
        .AxiWriteRespValid_ValIn    (bvalid),
        .AxiWriteRespReady_RdyOut   (bready),
        .AxiWriteRespResponse_DatIn (bresp),
        .AxiReadAddrValid_ValOut    (arvalid),
        .AxiReadAddrReady_RdyIn     (arready),
        .AxiReadAddrAddress_AdrOut  (araddr),
        .AxiReadAddrProt_DatOut     (arprot),
        .AxiReadDataValid_ValIn     (rvalid),
        .AxiReadDataReady_RdyOut    (rready),
        .AxiReadDataResponse_DatIn  (rresp),
        .AxiReadDataData_DatIn      (rdata)
    );

    // ROM model: registered read, one cycle of latency
    logic [65:0] rom [0:255];
    always @(posedge clk) cfg_entry <= rom[cfg_idx];

    // Slave knobs, driven only by the stimulus process
    int          aw_lat, w_lat, ar_lat, bad_b_num;
    bit          ar_never;
    logic [31:0] rd_xor;

    int          aw_cnt, w_cnt, ar_cnt, wr_num;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, w_data_s, aw_eff, w_eff;
    logic [31:0] mem [0:15];

    assign awready = awvalid && (aw_cnt == aw_lat);
    assign wready  = wvalid && (w_cnt == w_lat);
    assign arready = arvalid && !ar_never && (ar_cnt == ar_lat);
    assign rresp   = 2'b00;
    assign aw_eff  = aw_got ? aw_addr_s : awaddr;
    assign w_eff   = w_got ? w_data_s : wdata;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
            ar_cnt <= 0;
            wr_num <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rdata  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 32'hCAFE_F00D;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid           <= 1'b1;
                bresp            <= (wr_num == bad_b_num) ? 2'b10 : 2'b00;
                mem[aw_eff[5:2]] <= w_eff;
                wr_num           <= wr_num + 1;
                aw_got           <= 1'b0;
                w_got            <= 1'b0;
            end else begin
                if (awvalid && awready) begin
                    aw_got    <= 1'b1;
                    aw_addr_s <= awaddr;
                end
                if (wvalid && wready) begin
                    w_got    <= 1'b1;
                    w_data_s <= wdata;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[5:2]] ^ rd_xor;
            end
        end
    end

    // Bus monitor, sampled on the falling edge
    int          cyc, awv_cycles, wv_cycles, arv_cycles;
    int          aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, n_rise, b_hs_cyc;
    int          awv_rise [0:3];
    logic [31:0] hs_addr [0:7];
    logic [31:0] hs_data [0:7];
    logic        awv_prev, strb_ok;

    always @(negedge clk) begin
        if (rst) begin
            cyc        <= 0;
            awv_cycles <= 0;
            wv_cycles  <= 0;
            arv_cycles <= 0;
            aw_hs_n    <= 0;
            w_hs_n     <= 0;
            b_hs_n     <= 0;
            ar_hs_n    <= 0;
            n_rise     <= 0;
            b_hs_cyc   <= 0;
            awv_prev   <= 1'b0;
            strb_ok    <= 1'b1;
        end else begin
            cyc      <= cyc + 1;
            awv_prev <= awvalid;
            if (awvalid) awv_cycles <= awv_cycles + 1;
            if (wvalid) wv_cycles <= wv_cycles + 1;
            if (arvalid) arv_cycles <= arv_cycles + 1;
            if (awvalid && !awv_prev && n_rise < 4) begin
                awv_rise[n_rise] <= cyc;
                n_rise           <= n_rise + 1;
            end
            if (awvalid && awready) begin
                if (aw_hs_n < 8) hs_addr[aw_hs_n] <= awaddr;
                aw_hs_n <= aw_hs_n + 1;
            end
            if (wvalid && wready) begin
                if (w_hs_n < 8) hs_data[w_hs_n] <= wdata;
                if (wstrb != 4'hF) strb_ok <= 1'b0;
                w_hs_n <= w_hs_n + 1;
            end
            if (bvalid && bready) begin
                if (b_hs_n == 0) b_hs_cyc <= cyc;
                b_hs_n <= b_hs_n + 1;
            end
            if (arvalid && arready) ar_hs_n <= ar_hs_n + 1;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (conf_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(conf_done), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [65:0] ent(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] d);
        return {op, a, d};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ent(2'd3, 32'd0, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        aw_lat    = 0;
        w_lat     = 0;
        ar_lat    = 0;
        bad_b_num = -1;
        ar_never  = 1'b0;
        rd_xor    = '0;
        clear_rom();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_prot", 32'({awprot, arprot}), 32'd0);
        check("rst_strobe", 32'(wstrb), 32'hF);
        check("rst_index", 32'(cfg_idx), 32'd0);
        check("rst_done", 32'(conf_done), 32'd0);
        check("rst_error", 32'(conf_err), 32'd0);
        check("rst_erridx", 32'(err_idx), 32'd0);
        check("rst_lastrd", last_rd, 32'd0);

        // Two back-to-back writes with a zero-wait slave
        rom[0] = ent(2'd0, 32'h0001_0000, 32'h1);
        rom[1] = ent(2'd0, 32'h0001_0004, 32'h5);
        apply_reset();
        wait_done("t1", 200);
        check("t1_error", 32'(conf_err), 32'd0);
        check("t1_aw_hs", 32'(aw_hs_n), 32'd2);
        check("t1_w_hs", 32'(w_hs_n), 32'd2);
        check("t1_b_hs", 32'(b_hs_n), 32'd2);
        check("t1_addr0", hs_addr[0], 32'h0001_0000);
        check("t1_data0", hs_data[0], 32'h1);
        check("t1_addr1", hs_addr[1], 32'h0001_0004);
        check("t1_data1", hs_data[1], 32'h5);
        check("t1_strobe", 32'(strb_ok), 32'd1);
`ifdef CONF_MASTER_VERIFY_EN
        check("t1_ar_hs", 32'(ar_hs_n), 32'd2);
        check("t1_wr_spacing", 32'(awv_rise[1] - awv_rise[0]), 32'd7);
`else
        check("t1_ar_hs", 32'(ar_hs_n), 32'd0);
        check("t1_wr_spacing", 32'(awv_rise[1] - awv_rise[0]), 32'd5);
`endif

        // AWREADY on cycle 1, WREADY on cycle 5
        clear_rom();
        rom[0] = ent(2'd0, 32'h0000_0008, 32'h77);
        aw_lat = 0;
        w_lat  = 4;
        apply_reset();
        wait_done("t2", 200);
        check("t2_awv_cycles", 32'(awv_cycles), 32'd1);
        check("t2_wv_cycles", 32'(wv_cycles), 32'd5);
        check("t2_b_hs", 32'(b_hs_n), 32'd1);
        check("t2_error", 32'(conf_err), 32'd0);
        w_lat = 0;

        // WAIT 100 between two writes
        clear_rom();
        rom[0] = ent(2'd0, 32'h0000_0010, 32'h11);
        rom[1] = ent(2'd2, 32'h0, 32'd100);
        rom[2] = ent(2'd0, 32'h0000_0014, 32'h22);
        apply_reset();
        wait_done("t3", 400);
        check("t3_aw_hs", 32'(aw_hs_n), 32'd2);
`ifdef CONF_MASTER_VERIFY_EN
        check("t3_wait_gap", 32'(awv_rise[1] - b_hs_cyc), 32'd108);
`else
        check("t3_wait_gap", 32'(awv_rise[1] - b_hs_cyc), 32'd106);
`endif

        // Slave error on the write at entry 2
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = ent(2'd0, 32'(i * 4), 32'(i + 1));
        bad_b_num = 2;
        apply_reset();
        wait_done("t4", 300);
        repeat (20) @(negedge clk);
        check("t4_error", 32'(conf_err), 32'd1);
        check("t4_erridx", 32'(err_idx), 32'd2);
        check("t4_done_held", 32'(conf_done), 32'd1);
        check("t4_aw_hs", 32'(aw_hs_n), 32'd3);
`ifdef CONF_MASTER_VERIFY_EN
        check("t4_ar_hs", 32'(ar_hs_n), 32'd2);
`else
        check("t4_ar_hs", 32'(ar_hs_n), 32'd0);
`endif
        bad_b_num = -1;

        // ARREADY never comes: reset mid-transaction, then timeout, then restart
        clear_rom();
        rom[0] = ent(2'd1, 32'h0000_2000, 32'h0);
        ar_never = 1'b1;
        apply_reset();
        repeat (10) @(negedge clk);
        check("t5_busy_arvalid", 32'(arvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_midrst_arvalid", 32'(arvalid), 32'd0);
        check("t5_midrst_index", 32'(cfg_idx), 32'd0);
        rst = 1'b0;
        wait_done("t5", 1300);
        check("t5_arv_cycles", 32'(arv_cycles), 32'd1024);
        check("t5_error", 32'(conf_err), 32'd1);
        check("t5_erridx", 32'(err_idx), 32'd0);
        ar_never = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_restart_done_clr", 32'(conf_done), 32'd0);
        wait_done("t5_rerun", 200);
        check("t5_rerun_error", 32'(conf_err), 32'd0);
        check("t5_rerun_ar_hs", 32'(ar_hs_n), 32'd1);
        check("t5_lastrd", last_rd, 32'hCAFE_F00D);

        // Readback that differs from the written value
        clear_rom();
        rom[0] = ent(2'd0, 32'h0001_0004, 32'h5);
        rd_xor = 32'h1;
        apply_reset();
        wait_done("t6", 200);
`ifdef CONF_MASTER_VERIFY_EN
        check("t6_error", 32'(conf_err), 32'd1);
        check("t6_erridx", 32'(err_idx), 32'd0);
        check("t6_lastrd", last_rd, 32'h4);
        check("t6_ar_hs", 32'(ar_hs_n), 32'd1);
`else
        check("t6_error", 32'(conf_err), 32'd0);
        check("t6_lastrd", last_rd, 32'h0);
        check("t6_ar_hs", 32'(ar_hs_n), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
